// File: rtl/td4_pkg.sv
// ---------------------------------------------------------------------------
// td4_pkg
// Shared definitions for the TD4 instruction memory slice: the loader FSM
// state type, the memory depth and the TD4 opcode encodings.
// No ports (package).
// ---------------------------------------------------------------------------
package td4_pkg;

  // Loader FSM: IDLE after reset, LOAD while the host streams a program,
  // RUN while the CPU fetches from the stored program.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } td4_state_e;

  localparam int IMEM_DEPTH = 16;

  localparam logic [3:0] ADD_A    = 4'b0000;
  localparam logic [3:0] ADD_B    = 4'b1010;
  localparam logic [3:0] MOV_A_IM = 4'b1100;
  localparam logic [3:0] MOV_B_IM = 4'b1110;
  localparam logic [3:0] MOV_A_B  = 4'b1000;
  localparam logic [3:0] MOV_B_A  = 4'b0010;

  // Builds a program byte from its opcode and immediate fields.
  function automatic logic [7:0] packInstr(input logic [3:0] op, input logic [3:0] imm);
    return {op, imm};
  endfunction

endpackage

// File: rtl/td4_imem_array.sv
// ---------------------------------------------------------------------------
// td4_imem_array
// 16 x 8 program storage with one write port and one registered read port.
// Every entry returns to RESET_WORD while i_rst_n is low (synchronous).
//
// Ports:
//   i_clk      clock, all updates on the rising edge
//   i_rst_n    synchronous active-low reset
//   i_wrEn     write strobe
//   i_wrAddr   write address (0..15)
//   i_wrData   write data
//   i_rdEn     read enable; when low the read register is cleared to 0
//   i_rdAddr   read address (0..15)
//   o_rdData   registered read data
// ---------------------------------------------------------------------------
module td4_imem_array
  import td4_pkg::*;
#(
  parameter logic [7:0] RESET_WORD = 8'h00
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_wrEn,
  input  logic [3:0] i_wrAddr,
  input  logic [7:0] i_wrData,
  input  logic       i_rdEn,
  input  logic [3:0] i_rdAddr,
  output logic [7:0] o_rdData
);

  logic [7:0] r_mem [IMEM_DEPTH];
  logic [7:0] r_rdData;

  // Storage: reset wipes the whole program so a half-loaded image can never
  // be executed; otherwise only the addressed entry changes on a write.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < IMEM_DEPTH; i++) begin
        r_mem[i] <= RESET_WORD;
      end
    end else if (i_wrEn) begin
      r_mem[i_wrAddr] <= i_wrData;
    end
  end

  // Read register: clearing it when not enabled lets the top present zeros
  // outside RUN without any combinational gating on the outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rdData <= 8'h00;
    end else if (i_rdEn) begin
      r_rdData <= r_mem[i_rdAddr];
    end else begin
      r_rdData <= 8'h00;
    end
  end

  assign o_rdData = r_rdData;

endmodule

// File: rtl/td4_imem.sv
// ---------------------------------------------------------------------------
// td4_imem
// Loadable instruction memory for a TD4 CPU. A host streams up to 16 program
// bytes while load_en is high; the block then switches to RUN, releases the
// CPU (cpu_run) and serves registered fetches addressed by pc.
//
// Ports:
//   clk         clock, rising edge
//   rst_n       synchronous active-low reset
//   load_en     level request to enter/stay in program-load mode
//   wr_valid    host presents a byte on wr_data
//   wr_data     program byte {opcode, immediate}
//   wr_ready    a byte is accepted this cycle if wr_valid is high
//   pc          fetch address
//   opcode      fetched opcode (registered, 0 outside RUN)
//   immediate   fetched immediate (registered, 0 outside RUN)
//   cpu_run     high only in RUN
//   load_count  bytes accepted in the current/most recent load (0..16)
//   checksum    XOR of bytes accepted since the last entry into LOAD
//               (present only when TD4_IMEM_CHECKSUM_EN is defined)
//
// Configuration macro: TD4_IMEM_CHECKSUM_EN
// ---------------------------------------------------------------------------
module td4_imem
  import td4_pkg::*;
#(
  parameter logic [7:0] RESET_WORD = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_en,
  input  logic       wr_valid,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  input  logic [3:0] pc,
  output logic [3:0] opcode,
  output logic [3:0] immediate,
  output logic       cpu_run,
  output logic [4:0] load_count
`ifdef TD4_IMEM_CHECKSUM_EN
  ,
  output logic [7:0] checksum
`endif
);

  td4_state_e r_state;
  td4_state_e w_nextState;
  logic [4:0] r_loadCount;
  logic       r_cpuRun;
  logic       w_accept;
  logic       w_lastByte;
  logic       w_enterLoad;
  logic [7:0] w_rdData;

  // Ready depends only on registered state so the host never sees a
  // combinational path from its own wr_valid.
  assign wr_ready    = (r_state == LOAD) && (r_loadCount < 5'(IMEM_DEPTH));
  assign w_accept    = wr_valid && wr_ready;
  assign w_lastByte  = (r_loadCount == 5'(IMEM_DEPTH - 1));
  assign w_enterLoad = (w_nextState == LOAD) && (r_state != LOAD);

  // Next-state logic. Leaving LOAD on a dropped load_en still honours a byte
  // accepted on that same edge, because the write uses w_accept directly.
  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      IDLE: if (load_en) w_nextState = LOAD;
      LOAD: if (!load_en || (w_accept && w_lastByte)) w_nextState = RUN;
      RUN:  if (load_en) w_nextState = LOAD;
      default: w_nextState = IDLE;
    endcase
  end

  // State, byte counter and cpu_run. cpu_run is taken from the next state so
  // the register always equals (state == RUN).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_loadCount <= 5'd0;
      r_cpuRun    <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_cpuRun <= (w_nextState == RUN);
      if (w_enterLoad) begin
        r_loadCount <= 5'd0;
      end else if (w_accept) begin
        r_loadCount <= r_loadCount + 5'd1;
      end
    end
  end

  // Read enable follows the next state, so the first RUN cycle already
  // shows mem[pc] sampled on the transition edge.
  td4_imem_array #(
    .RESET_WORD (RESET_WORD)
  ) u_array (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_wrEn   (w_accept),
    .i_wrAddr (r_loadCount[3:0]),
    .i_wrData (wr_data),
    .i_rdEn   (w_nextState == RUN),
    .i_rdAddr (pc),
    .o_rdData (w_rdData)
  );

  assign opcode     = w_rdData[7:4];
  assign immediate  = w_rdData[3:0];
  assign cpu_run    = r_cpuRun;
  assign load_count = r_loadCount;

`ifdef TD4_IMEM_CHECKSUM_EN
  logic [7:0] r_checksum;

  // Running XOR of the program being loaded; restarts on every new load and
  // simply holds in RUN because nothing is accepted there.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_checksum <= 8'h00;
    end else if (w_enterLoad) begin
      r_checksum <= 8'h00;
    end else if (w_accept) begin
      r_checksum <= r_checksum ^ wr_data;
    end
  end

  assign checksum = r_checksum;
`endif

endmodule

// File: tb/tb_td4_imem.sv
// ---------------------------------------------------------------------------
// tb_td4_imem
// Self-checking bench for td4_imem: a table of per-cycle vectors followed by
// a randomised full load checked against a small memory model.
// Configuration macro: TD4_IMEM_CHECKSUM_EN (adds the checksum sequence).
// ---------------------------------------------------------------------------
module tb_td4_imem;
  import td4_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       load_en;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic [3:0] pc;
  logic [3:0] opcode;
  logic [3:0] immediate;
  logic       cpu_run;
  logic [4:0] load_count;
`ifdef TD4_IMEM_CHECKSUM_EN
  logic [7:0] checksum;
`endif

  int checkCount = 0;
  int failCount  = 0;

  td4_imem #(
    .RESET_WORD (8'h00)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_en    (load_en),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .pc         (pc),
    .opcode     (opcode),
    .immediate  (immediate),
    .cpu_run    (cpu_run),
    .load_count (load_count)
`ifdef TD4_IMEM_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rstN;
    logic       loadEn;
    logic       wrValid;
    logic [7:0] wrData;
    logic [3:0] pc;
    logic       expReady;
    logic       expRun;
    logic [4:0] expCount;
    logic       chkFetch;
    logic [7:0] expFetch;
  } vec_t;

  vec_t vecs[$];

  function automatic void addVec(string name, logic rstN, logic loadEn, logic wrValid,
                                 logic [7:0] wrData, logic [3:0] pcIn, logic expReady,
                                 logic expRun, logic [4:0] expCount, logic chkFetch,
                                 logic [7:0] expFetch);
    vec_t v;
    v.name = name; v.rstN = rstN; v.loadEn = loadEn; v.wrValid = wrValid;
    v.wrData = wrData; v.pc = pcIn; v.expReady = expReady; v.expRun = expRun;
    v.expCount = expCount; v.chkFetch = chkFetch; v.expFetch = expFetch;
    vecs.push_back(v);
  endfunction

  // Drives one cycle of inputs, lets one rising edge pass, then waits 1 ns
  // so outputs are sampled well away from the edge.
  task automatic applyStimulus(input logic rstN, input logic loadEn, input logic wrValid,
                               input logic [7:0] wrData, input logic [3:0] pcIn);
    rst_n    = rstN;
    load_en  = loadEn;
    wr_valid = wrValid;
    wr_data  = wrData;
    pc       = pcIn;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  logic [7:0] model [IMEM_DEPTH];

  initial begin
    rst_n    = 1'b0;
    load_en  = 1'b0;
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    pc       = 4'd0;

    // Reset, IDLE hold, full 16-byte load.
    addVec("rst0",       0, 0, 0, 8'h00, 4'd0, 0, 0, 5'd0,  1, 8'h00);
    addVec("rst1",       0, 0, 0, 8'h00, 4'd0, 0, 0, 5'd0,  1, 8'h00);
    addVec("idleHold",   1, 0, 0, 8'h00, 4'd0, 0, 0, 5'd0,  1, 8'h00);
    addVec("enterLoad",  1, 1, 0, 8'h00, 4'd0, 1, 0, 5'd0,  1, 8'h00);
    addVec("full1",      1, 1, 1, packInstr(MOV_A_IM, 4'd3), 4'd0, 1, 0, 5'd1, 1, 8'h00);
    addVec("full2",      1, 1, 1, packInstr(MOV_B_IM, 4'd5), 4'd0, 1, 0, 5'd2, 1, 8'h00);
    for (int k = 3; k <= 15; k++) begin
      addVec("fullN",    1, 1, 1, 8'h00, 4'd0, 1, 0, 5'(k), 1, 8'h00);
    end
    addVec("full16",     1, 1, 1, 8'h00, 4'd0, 0, 1, 5'd16, 0, 8'h00);
    addVec("fetch1",     1, 0, 0, 8'h00, 4'd1, 0, 1, 5'd16, 1, 8'hE5);
    addVec("fetch0",     1, 0, 0, 8'h00, 4'd0, 0, 1, 5'd16, 1, 8'hC3);
    addVec("refuse17",   1, 0, 1, 8'hFF, 4'd2, 0, 1, 5'd16, 1, 8'h00);
    // Reload from RUN, backpressure gaps, partial load.
    addVec("reload",     1, 1, 0, 8'h00, 4'd0, 1, 0, 5'd0,  1, 8'h00);
    addVec("gapV1",      1, 1, 1, 8'h81, 4'd0, 1, 0, 5'd1,  1, 8'h00);
    addVec("gapV0a",     1, 1, 0, 8'hAA, 4'd0, 1, 0, 5'd1,  1, 8'h00);
    addVec("gapV0b",     1, 1, 0, 8'hAA, 4'd0, 1, 0, 5'd1,  1, 8'h00);
    addVec("gapV1b",     1, 1, 1, 8'h27, 4'd0, 1, 0, 5'd2,  1, 8'h00);
    addVec("dropLoad",   1, 0, 0, 8'h00, 4'd2, 0, 1, 5'd2,  0, 8'h00);
    addVec("part2",      1, 0, 0, 8'h00, 4'd2, 0, 1, 5'd2,  1, 8'h00);
    addVec("part1",      1, 0, 0, 8'h00, 4'd1, 0, 1, 5'd2,  1, 8'h27);
    addVec("part0",      1, 0, 0, 8'h00, 4'd0, 0, 1, 5'd2,  1, 8'h81);
    // Byte accepted on the same cycle load_en falls; entry 1 must survive.
    addVec("reload2",    1, 1, 0, 8'h00, 4'd0, 1, 0, 5'd0,  1, 8'h00);
    addVec("byteDrop",   1, 0, 1, 8'hE2, 4'd0, 0, 1, 5'd1,  0, 8'h00);
    addVec("keep0",      1, 0, 0, 8'h00, 4'd0, 0, 1, 5'd1,  1, 8'hE2);
    addVec("keep1",      1, 0, 0, 8'h00, 4'd1, 0, 1, 5'd1,  1, 8'h27);
    // Reset in the middle of a load discards everything.
    addVec("reload3",    1, 1, 0, 8'h00, 4'd0, 1, 0, 5'd0,  1, 8'h00);
    addVec("mid1",       1, 1, 1, 8'h11, 4'd0, 1, 0, 5'd1,  1, 8'h00);
    addVec("mid2",       1, 1, 1, 8'h22, 4'd0, 1, 0, 5'd2,  1, 8'h00);
    addVec("mid3",       1, 1, 1, 8'h33, 4'd0, 1, 0, 5'd3,  1, 8'h00);
    addVec("mid4",       1, 1, 1, 8'h44, 4'd0, 1, 0, 5'd4,  1, 8'h00);
    addVec("mid5",       1, 1, 1, 8'h55, 4'd0, 1, 0, 5'd5,  1, 8'h00);
    addVec("midReset",   0, 1, 1, 8'h66, 4'd0, 0, 0, 5'd0,  1, 8'h00);
    addVec("newLoad",    1, 1, 0, 8'h00, 4'd0, 1, 0, 5'd0,  1, 8'h00);
    addVec("emptyLoad",  1, 0, 0, 8'h00, 4'd0, 0, 1, 5'd0,  0, 8'h00);
    addVec("zero0",      1, 0, 0, 8'h00, 4'd0, 0, 1, 5'd0,  1, 8'h00);
    addVec("zero1",      1, 0, 0, 8'h00, 4'd1, 0, 1, 5'd0,  1, 8'h00);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rstN, vecs[i].loadEn, vecs[i].wrValid, vecs[i].wrData, vecs[i].pc);
      checkOutput({vecs[i].name, ".wr_ready"}, 32'(wr_ready), 32'(vecs[i].expReady));
      checkOutput({vecs[i].name, ".cpu_run"}, 32'(cpu_run), 32'(vecs[i].expRun));
      checkOutput({vecs[i].name, ".load_count"}, 32'(load_count), 32'(vecs[i].expCount));
      if (vecs[i].chkFetch) begin
        checkOutput({vecs[i].name, ".fetch"}, 32'({opcode, immediate}), 32'(vecs[i].expFetch));
      end
    end

    // Randomised full load against a model, then every address fetched back.
    applyStimulus(1, 1, 0, 8'h00, 4'd0);
    checkOutput("rndEnter.load_count", 32'(load_count), 32'd0);
    for (int k = 0; k < IMEM_DEPTH; k++) begin
      model[k] = 8'($urandom_range(0, 255));
      applyStimulus(1, (k < IMEM_DEPTH - 1) ? 1'b1 : 1'b0, 1, model[k], 4'd0);
      checkOutput("rndLoad.load_count", 32'(load_count), 32'(k + 1));
    end
    checkOutput("rndDone.cpu_run", 32'(cpu_run), 32'd1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 0, 1, 8'h5C, 4'd0);
      checkOutput("rndOverflow.wr_ready", 32'(wr_ready), 32'd0);
      checkOutput("rndOverflow.load_count", 32'(load_count), 32'd16);
    end
    for (int k = 0; k < IMEM_DEPTH; k++) begin
      applyStimulus(1, 0, 0, 8'h00, 4'(k));
      checkOutput("rndFetch", 32'({opcode, immediate}), 32'(model[k]));
    end

`ifdef TD4_IMEM_CHECKSUM_EN
    // Checksum restarts on entry into LOAD and holds in RUN.
    applyStimulus(1, 1, 0, 8'h00, 4'd0);
    checkOutput("csEnter", 32'(checksum), 32'h00);
    applyStimulus(1, 1, 1, 8'hA5, 4'd0);
    checkOutput("csByte1", 32'(checksum), 32'hA5);
    applyStimulus(1, 1, 1, 8'h5A, 4'd0);
    checkOutput("csByte2", 32'(checksum), 32'hFF);
    applyStimulus(1, 1, 1, 8'hFF, 4'd0);
    checkOutput("csByte3", 32'(checksum), 32'h00);
    applyStimulus(1, 0, 0, 8'h00, 4'd0);
    applyStimulus(1, 0, 0, 8'h00, 4'd0);
    checkOutput("csHoldRun", 32'(checksum), 32'h00);
    applyStimulus(1, 1, 0, 8'h00, 4'd0);
    applyStimulus(1, 1, 1, 8'hA5, 4'd0);
    applyStimulus(1, 1, 1, 8'h5A, 4'd0);
    applyStimulus(1, 0, 0, 8'h00, 4'd0);
    checkOutput("csTwoBytes", 32'(checksum), 32'hFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
